// File: rtl/axi_sram_responder_if.sv
// AXI4 channel bundle between a CPU-side master and the SRAM responder.
// Write channels may be tied off by the master for read-only ports.
interface axi_sram_responder_if #(
  parameter int ID_W = 5
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 responder over a 64-bit word SRAM; independent single-burst read and
// write FSMs share the array. Errors still run the full beat handshake.
module axi_sram_responder #(
  parameter int          ID_W  = 5,
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096
) (
  input logic                 clk_i,
  input logic                 srst_i,
  axi_sram_responder_if.slave s_axi
);
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [32:0] LIMIT  = {1'b0, BASE} + 33'(DEPTH) * 33'd8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[AW+2:3];
  endfunction

  function automatic logic [1:0] burst_err(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] e;
    e = OKAY;
    if ({1'b0, a} < {1'b0, BASE} || {1'b0, a} >= LIMIT)
      e = DECERR;
    else if (size > 3'd3 || burst == 2'b11 ||
             (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15))
      e = SLVERR;
    return e;
  endfunction

  // WRAP keeps the bits above the (len+1)*step block and wraps the ones below.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, mask, n;
    step = 32'd1 << size;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   n = a;
      2'b10:   n = (a & ~mask) | ((a + step) & mask);
      default: n = a + step;
    endcase
    return n;
  endfunction

  logic [63:0] mem [DEPTH];
  logic        live_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // ---------------- read side ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  r_state_e r_state_q, r_state_d;

  logic [ID_W-1:0] rid_q;
  logic [31:0]     raddr_q, raddr_nx;
  logic [7:0]      rlen_q, rcnt_q;
  logic [2:0]      rsize_q;
  logic [1:0]      rburst_q, rresp_q, ar_err;
  logic [63:0]     rdata_q;
  logic            arready, rvalid, ar_hs, r_hs, r_last;

  assign ar_hs    = s_axi.arvalid && arready;
  assign r_hs     = rvalid && s_axi.rready;
  assign r_last   = (rcnt_q == rlen_q);
  assign ar_err   = burst_err(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
  assign raddr_nx = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

  always_ff @(posedge clk_i) begin
    if (srst_i) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)           r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_last)  r_state_d = R_IDLE;
      default:                      r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = live_q && (r_state_q == R_IDLE);
    rvalid  = (r_state_q == R_DATA);
  end

  // rdata is fetched one beat ahead so the master sees it with rvalid.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rid_q    <= s_axi.arid;
      raddr_q  <= s_axi.araddr;
      rlen_q   <= s_axi.arlen;
      rcnt_q   <= '0;
      rsize_q  <= s_axi.arsize;
      rburst_q <= s_axi.arburst;
      rresp_q  <= ar_err;
      rdata_q  <= (ar_err == OKAY) ? mem[word_idx(s_axi.araddr)] : '0;
    end else if (r_hs && !r_last) begin
      raddr_q  <= raddr_nx;
      rcnt_q   <= rcnt_q + 8'd1;
      rdata_q  <= (rresp_q == OKAY) ? mem[word_idx(raddr_nx)] : '0;
    end
  end

  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rlast   = rvalid && r_last;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // ---------------- write side ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  w_state_e w_state_q, w_state_d;

  logic [ID_W-1:0] wid_q;
  logic [31:0]     waddr_q, waddr_nx;
  logic [7:0]      wlen_q, wcnt_q;
  logic [2:0]      wsize_q;
  logic [1:0]      wburst_q, werr_q, aw_err, bresp_q;
  logic            wbad_q, w_bad_now;
  logic            awready, wready, bvalid, aw_hs, w_hs, w_last;

  assign aw_hs     = s_axi.awvalid && awready;
  assign w_hs      = s_axi.wvalid && wready;
  assign w_last    = (wcnt_q == wlen_q);
  assign w_bad_now = (s_axi.wlast != w_last);
  assign aw_err    = burst_err(s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst);
  assign waddr_nx  = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);

  always_ff @(posedge clk_i) begin
    if (srst_i) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)          w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last) w_state_d = W_RESP;
      W_RESP:  if (s_axi.bready)   w_state_d = W_IDLE;
      default:                     w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = live_q && (w_state_q == W_IDLE);
    wready  = (w_state_q == W_DATA);
    bvalid  = (w_state_q == W_RESP);
  end

  // Address/decode errors win over a wlast mismatch on B.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      werr_q   <= OKAY;
      wbad_q   <= 1'b0;
      bresp_q  <= OKAY;
    end else if (aw_hs) begin
      wid_q    <= s_axi.awid;
      waddr_q  <= s_axi.awaddr;
      wlen_q   <= s_axi.awlen;
      wcnt_q   <= '0;
      wsize_q  <= s_axi.awsize;
      wburst_q <= s_axi.awburst;
      werr_q   <= aw_err;
      wbad_q   <= 1'b0;
    end else if (w_hs) begin
      waddr_q  <= waddr_nx;
      wcnt_q   <= wcnt_q + 8'd1;
      wbad_q   <= wbad_q | w_bad_now;
      if (w_last)
        bresp_q <= (werr_q != OKAY)         ? werr_q :
                   (wbad_q || w_bad_now)    ? SLVERR : OKAY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i && w_hs && werr_q == OKAY) begin
      for (int b = 0; b < 8; b++)
        if (s_axi.wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
    end
  end

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bid     = wid_q;
  assign s_axi.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: a byte-level memory model predicts
// every R and B beat; a negedge process checks them as they are handshaken.
module tb_axi_sram_responder;
  localparam int          ID_W  = 5;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_responder_if #(.ID_W(ID_W)) ax();

  axi_sram_responder #(.ID_W(ID_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .srst_i(srst),
    .s_axi (ax)
  );

  assign ax.bready = 1'b1;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } rbeat_t;
  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } bbeat_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rr_mode = 0;
  rbeat_t      exp_r[$];
  bbeat_t      exp_b[$];
  logic [63:0] got_d[$];
  logic [1:0]  got_resp[$];
  logic [1:0]  last_bresp;
  logic [63:0] mdl [int];
  logic [63:0] w_data [16];
  logic [7:0]  w_strb [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic lit_d(input string name, input int idx, input logic [63:0] exp);
    if (got_d.size() > idx) check(name, got_d[idx], exp);
    else begin
      n_cmp++; n_bad++;
      $display("FAIL %s: beat %0d never returned, expected %h", name, idx, exp);
    end
  endtask

  // ---- model: spec rules in plain arithmetic ----
  function automatic logic [1:0] err_of(input logic [31:0] a, input int len, input int size, input int burst);
    longint unsigned la = 64'(a);
    if (la < 64'(BASE) || la >= 64'(BASE) + 64'(8 * DEPTH)) return 2'b11;
    if (size > 3 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}))) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    logic [31:0] step, blk, lo;
    step = 32'd1 << size;
    if (burst == 0) return a;
    if (burst != 2) return a + 32'(i) * step;
    blk = 32'(len + 1) * step;
    lo  = a - (a % blk);
    return lo + ((a - lo) + 32'(i) * step) % blk;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE) >> 3) % DEPTH);
  endfunction

  function automatic logic [63:0] rdmem(input int w);
    return mdl.exists(w) ? mdl[w] : 64'h0;
  endfunction

  always @(posedge clk) begin
    #1;
    ax.rready = (rr_mode == 1) ? ~ax.rready : 1'b1;
  end

  // ---- compare process ----
  logic            stall_q = 1'b0;
  logic [ID_W-1:0] h_id;
  logic [63:0]     h_d;
  logic [1:0]      h_resp;
  logic            h_last;

  always @(negedge clk) begin
    rbeat_t er;
    bbeat_t eb;
    if (srst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("r_hold_valid", 64'(ax.rvalid), 64'd1);
        check("r_hold_id",    64'(ax.rid),    64'(h_id));
        check("r_hold_data",  ax.rdata,       h_d);
        check("r_hold_resp",  64'(ax.rresp),  64'(h_resp));
        check("r_hold_last",  64'(ax.rlast),  64'(h_last));
      end
      if (ax.rvalid && ax.rready) begin
        n_cmp++;
        if (exp_r.size() == 0) begin
          n_bad++;
          $display("FAIL r_unexpected: R beat data %h with nothing outstanding", ax.rdata);
        end else begin
          er = exp_r.pop_front();
          check("r_id",   64'(ax.rid),   64'(er.id));
          check("r_data", ax.rdata,      er.data);
          check("r_resp", 64'(ax.rresp), 64'(er.resp));
          check("r_last", 64'(ax.rlast), 64'(er.last));
          got_d.push_back(ax.rdata);
          got_resp.push_back(ax.rresp);
        end
      end
      if (ax.bvalid && ax.bready) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_bad++;
          $display("FAIL b_unexpected: B resp %b with nothing outstanding", ax.bresp);
        end else begin
          eb = exp_b.pop_front();
          check("b_id",   64'(ax.bid),   64'(eb.id));
          check("b_resp", 64'(ax.bresp), 64'(eb.resp));
          last_bresp <= ax.bresp;
        end
      end
      stall_q <= ax.rvalid && !ax.rready;
      h_id    <= ax.rid;
      h_d     <= ax.rdata;
      h_resp  <= ax.rresp;
      h_last  <= ax.rlast;
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_r.size() != 0 || exp_b.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout, %0d R and %0d B beats still owed", name, exp_r.size(), exp_b.size());
      exp_r.delete();
      exp_b.delete();
    end
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input bit drain);
    int     n;
    rbeat_t e;
    logic [1:0] err;
    got_d.delete();
    got_resp.delete();
    @(posedge clk); #1;
    ax.arid = id; ax.araddr = addr; ax.arlen = 8'(len);
    ax.arsize = 3'(size); ax.arburst = 2'(burst); ax.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ax.arready && n < 100);
    if (!ax.arready) begin
      n_cmp++; n_bad++;
      $display("FAIL ar_timeout: arready still 0 after %0d cycles, expected 1", n);
    end else begin
      err = err_of(addr, len, size, burst);
      for (int i = 0; i <= len; i++) begin
        e.id   = id;
        e.resp = err;
        e.data = (err != 2'b00) ? 64'h0 : rdmem(word_of(beat_addr(addr, len, size, burst, i)));
        e.last = (i == len);
        exp_r.push_back(e);
      end
    end
    @(posedge clk); #1;
    ax.arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", 64'(ax.rvalid), 64'd1);
    if (drain) wait_drain("read");
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int last_at);
    int          n;
    bbeat_t      eb;
    logic [1:0]  err;
    logic [63:0] v;
    int          w;
    err     = err_of(addr, len, size, burst);
    eb.id   = id;
    eb.resp = (err != 2'b00) ? err : ((last_at != len) ? 2'b10 : 2'b00);
    exp_b.push_back(eb);
    if (err == 2'b00)
      for (int i = 0; i <= len; i++) begin
        w = word_of(beat_addr(addr, len, size, burst, i));
        v = rdmem(w);
        for (int b = 0; b < 8; b++) if (w_strb[i][b]) v[b*8 +: 8] = w_data[i][b*8 +: 8];
        mdl[w] = v;
      end
    @(posedge clk); #1;
    ax.awid = id; ax.awaddr = addr; ax.awlen = 8'(len);
    ax.awsize = 3'(size); ax.awburst = 2'(burst); ax.awvalid = 1'b1;
    ax.wdata = w_data[0]; ax.wstrb = w_strb[0]; ax.wlast = (last_at == 0); ax.wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) check("w_before_aw", 64'(ax.wready), 64'd0);
      n++;
    end while (!ax.awready && n < 100);
    if (!ax.awready) begin
      n_cmp++; n_bad++;
      $display("FAIL aw_timeout: awready still 0, expected 1");
    end
    @(posedge clk); #1;
    ax.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        if (i == 0 && n == 0) check("wready_latency", 64'(ax.wready), 64'd1);
        n++;
      end while (!ax.wready && n < 100);
      if (!ax.wready) begin
        n_cmp++; n_bad++;
        $display("FAIL w_timeout: wready 0 on beat %0d, expected 1", i);
      end
      @(posedge clk); #1;
      if (i < len) begin
        ax.wdata = w_data[i+1]; ax.wstrb = w_strb[i+1]; ax.wlast = (last_at == i + 1);
      end else begin
        ax.wvalid = 1'b0; ax.wlast = 1'b0;
      end
    end
    @(negedge clk);
    check("b_latency", 64'(ax.bvalid), 64'd1);
    wait_drain("write");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ax.arvalid = 1'b0; ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arsize = '0; ax.arburst = '0;
    ax.awvalid = 1'b0; ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awsize = '0; ax.awburst = '0;
    ax.wvalid = 1'b0; ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0;
    for (int i = 0; i < 16; i++) w_strb[i] = 8'hFF;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(ax.arready), 64'd0);
    check("rst_awready", 64'(ax.awready), 64'd0);
    check("rst_wready",  64'(ax.wready),  64'd0);
    check("rst_rvalid",  64'(ax.rvalid),  64'd0);
    check("rst_rlast",   64'(ax.rlast),   64'd0);
    check("rst_bvalid",  64'(ax.bvalid),  64'd0);
    check("rst_rid",     64'(ax.rid),     64'd0);
    check("rst_rdata",   ax.rdata,        64'd0);
    check("rst_rresp",   64'(ax.rresp),   64'd0);
    check("rst_bid",     64'(ax.bid),     64'd0);
    check("rst_bresp",   64'(ax.bresp),   64'd0);
    @(posedge clk); #1;
    srst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("arready_after_rst", 64'(ax.arready), 64'd1);
    check("awready_after_rst", 64'(ax.awready), 64'd1);

    // single beat write and readback
    w_data[0] = 64'h1122_3344_5566_7788;
    do_write(5'h0A, 32'h8000_0010, 0, 3, 1, 0);
    do_read(5'h13, 32'h8000_0010, 0, 3, 1, 1'b1);
    lit_d("single_rd_lit", 0, 64'h1122_3344_5566_7788);

    // INCR len 3, read back with rready toggling
    for (int i = 0; i < 4; i++) w_data[i] = 64'hA0 + 64'(i);
    do_write(5'h01, 32'h8000_0100, 3, 3, 1, 3);
    rr_mode = 1;
    do_read(5'h02, 32'h8000_0100, 3, 3, 1, 1'b1);
    rr_mode = 0;
    lit_d("incr_rd_b3", 3, 64'hA3);

    // WRAP len 3 from 0x118
    do_read(5'h03, 32'h8000_0118, 3, 3, 2, 1'b1);
    lit_d("wrap_b0", 0, 64'hA3);
    lit_d("wrap_b1", 1, 64'hA0);
    lit_d("wrap_b2", 2, 64'hA1);
    lit_d("wrap_b3", 3, 64'hA2);

    // DECERR read below BASE, DECERR write past the end (aliases word 0)
    do_read(5'h04, 32'h7FFF_FFF8, 1, 3, 1, 1'b1);
    lit_d("decerr_rd_data", 1, 64'h0);
    if (got_resp.size() > 1) check("decerr_rd_resp", 64'(got_resp[1]), 64'd3);
    w_data[0] = 64'h5555_AAAA_5555_AAAA;
    do_write(5'h05, 32'h8000_0000, 0, 3, 1, 0);
    w_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(5'h06, 32'h8000_8000, 0, 3, 1, 0);
    check("decerr_wr_lit", 64'(last_bresp), 64'd3);
    do_read(5'h07, 32'h8000_0000, 0, 3, 1, 1'b1);
    lit_d("decerr_mem_kept", 0, 64'h5555_AAAA_5555_AAAA);

    // partial strobe
    w_data[0] = 64'hDEAD_BEEF_CAFE_F00D;
    w_strb[0] = 8'h0F;
    do_write(5'h08, 32'h8000_0010, 0, 3, 1, 0);
    w_strb[0] = 8'hFF;
    do_read(5'h09, 32'h8000_0010, 0, 3, 1, 1'b1);
    lit_d("partial_lit", 0, 64'h1122_3344_CAFE_F00D);

    // wlast on the wrong beat: SLVERR but data kept
    for (int i = 0; i < 3; i++) w_data[i] = 64'hB0 + 64'(i);
    do_write(5'h0B, 32'h8000_0200, 2, 3, 1, 1);
    check("wlast_bad_lit", 64'(last_bresp), 64'd2);
    do_read(5'h0C, 32'h8000_0200, 2, 3, 1, 1'b1);
    lit_d("wlast_bad_data", 2, 64'hB2);

    // SLVERR: oversize write suppressed, bad WRAP length on read
    w_data[0] = 64'h3333;
    do_write(5'h0D, 32'h8000_0300, 0, 3, 1, 0);
    w_data[0] = 64'hFFFF;
    do_write(5'h0E, 32'h8000_0300, 0, 4, 1, 0);
    check("slverr_wr_lit", 64'(last_bresp), 64'd2);
    do_read(5'h0F, 32'h8000_0300, 0, 3, 1, 1'b1);
    lit_d("slverr_mem_kept", 0, 64'h3333);
    do_read(5'h10, 32'h8000_0100, 2, 3, 2, 1'b1);
    if (got_resp.size() > 2) check("slverr_rd_resp", 64'(got_resp[2]), 64'd2);
    lit_d("slverr_rd_data", 0, 64'h0);

    // reset during beat 2 of a len 7 read
    do_read(5'h11, 32'h8000_0100, 7, 3, 1, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid",  64'(ax.rvalid),  64'd0);
    check("rst_mid_arready", 64'(ax.arready), 64'd0);
    check("rst_mid_beats",   64'(got_d.size()), 64'd2);
    exp_r.delete();
    @(negedge clk);
    check("rst_mid_arready_up", 64'(ax.arready), 64'd1);
    do_read(5'h12, 32'h8000_0100, 3, 3, 1, 1'b1);
    lit_d("after_rst_rd", 1, 64'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 slave (responder) backed by an on-chip SRAM array. It terminates one CPU-side AXI master port set: the full dbus read/write set, or a read-only ibus/immu/dmmu set with the write channels tied off. Read and write channels run independent state machines over a shared word array. It is the standard memory model for core-level simulation and the boot/scratch RAM for FPGA builds.

## Interface
- ID_W, 5: width of arid/rid/awid/bid (use 4 for ibus/mmu ports).
- BASE, 32'h8000_0000: byte address of word 0; must be 8-byte aligned.
- DEPTH, 4096: number of 64-bit words; power of two.
- clk_i  in  1  clock; all logic rising-edge.
- srst_i  in  1  reset, synchronous, active-high.
- s_axi_arid / araddr / arlen / arsize / arburst  in  ID_W/32/8/3/2  read address.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid / rdata / rresp / rlast / rvalid  out  ID_W/64/2/1/1  read data.
- s_axi_rready  in  1.
- s_axi_awid / awaddr / awlen / awsize / awburst  in  ID_W/32/8/3/2  write address.
- s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata / wstrb / wlast / wvalid  in  64/8/1/1  write data;  s_axi_wready  out  1.
- s_axi_bid / bresp / bvalid  out  ID_W/2/1  write response;  s_axi_bready  in  1.

## Operation
- Read FSM: R_IDLE -> R_DATA -> R_IDLE. Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE. Each FSM holds one burst; no outstanding queue, no reordering.
- R_IDLE: arready=1. On an AR handshake, latch id, addr, len, size, burst, and beat counter=0, then go to R_DATA.
- R_DATA: rvalid=1. rlast=1 when counter==len. On an R handshake, advance the address and counter. On the handshake with rlast=1, return to R_IDLE.
- W_IDLE: awready=1, wready=0. On an AW handshake, latch the fields and go to W_DATA.
- W_DATA: wready=1. Each W handshake writes mem[word] byte-wise under wstrb, then advances. The beat counter alone ends the burst; wlast is only checked. After the beat with counter==len, go to W_RESP.
- W_RESP: bvalid=1, bid=latched id. Hold until bready, then go to W_IDLE.
- Address update per beat, with step=1<<size:
  - FIXED: unchanged.
  - INCR: addr+step.
  - WRAP: addr+step, wrapped inside the aligned block of (len+1)*step bytes.
- Word index = (addr-BASE)>>3, truncated to log2(DEPTH) bits. Narrow reads return the full 64-bit word; the master selects the lanes.
- Response codes:
  - OKAY (2'b00) by default.
  - DECERR (2'b11): a burst whose start address lies outside [BASE, BASE+8*DEPTH). Returned on every R beat with rdata=0, or once on B with writes suppressed.
  - SLVERR (2'b10): size>3, burst==2'b11, or WRAP with len not in {1,3,7,15}. Writes are suppressed and rdata=0.
  - SLVERR also on B if wlast disagrees with the counter on any beat. Data of this kind of burst is still written.
- Error bursts still complete the full len+1 beat handshake.

## Timing
- While srst_i=1 at an edge, all outputs go to 0 on that edge: arready, awready, wready, rvalid, rlast, bvalid, rid, rdata, rresp, bid, bresp. Both FSMs go to idle. Memory contents are not reset.
- arready/awready are 1 from the first cycle after srst_i falls.
- Read latency: rvalid rises on the cycle after the AR handshake.
- rdata is registered. It is loaded at the AR-handshake edge (beat 0) and at each non-final R-handshake edge (next beat).
- Read-before-write: a write committed at the same edge as an rdata load is not visible in that beat.
- While rvalid=1 and rready=0, rid/rdata/rresp/rlast are held stable. Full throughput is 1 beat per cycle.
- arready is 0 in R_DATA; the next AR is accepted at the earliest on the cycle after the final R handshake. AW follows the same rule after the B handshake.
- wready rises the cycle after the AW handshake. bvalid rises the cycle after the last W handshake.
- W beats presented before an AW handshake are not accepted (wready=0).
- If srst_i is asserted mid-burst, the burst is abandoned with no further beats. Memory writes already committed are retained.

## Test plan
- Write 0x1122334455667788 to 0x8000_0010 (INCR, len 0, wstrb 0xFF), then read it back -> bresp 00; rdata matches; rlast=1; rid/bid echo the request ids.
- INCR len 3 write of 0xA0..0xA3 at 0x8000_0100, then read with rready low every other cycle -> 4 beats in order, data stable during stalls, rlast only on beat 3.
- WRAP len 3 read at 0x8000_0118 -> beats from 0x118, 0x100, 0x108, 0x110.
- Read at 0x7FFF_FFF8 with len 1 -> 2 beats, rresp 11, rdata 0. Write at BASE+8*DEPTH -> bresp 11, memory unchanged.
- Partial write with wstrb 0x0F, then read -> only the low 4 bytes change. A write burst with wlast on the wrong beat -> bresp 10.
- srst_i pulsed during beat 2 of a len 7 read -> rvalid=0 on the next cycle; arready=1 one cycle after srst_i falls; a new read completes normally.
